// File: rtl/bus_responder_pkg.sv
// Shared bus definitions: MMIO page location, register offsets, STATUS
// bit positions and the decode helper used by the responder.
package bus_responder_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_F000;

    localparam logic [11:0] OFS_CONSOLE_TX = 12'h000;
    localparam logic [11:0] OFS_STATUS     = 12'h004;
    localparam logic [11:0] OFS_TIMER      = 12'h008;
    localparam logic [11:0] OFS_HALT       = 12'h00C;

    localparam int STATUS_EMPTY_BIT    = 0;
    localparam int STATUS_FULL_BIT     = 1;
    localparam int STATUS_COUNT_LSB    = 2;
    localparam int STATUS_COUNT_MSB    = 7;
    localparam int STATUS_OVERFLOW_BIT = 8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_CONSOLE,
        SEL_STATUS,
        SEL_TIMER,
        SEL_HALT
    } bus_sel_e;

    // Map a word offset inside the MMIO page to its register; the byte
    // lane bits are not passed in because all accesses are whole words.
    function automatic bus_sel_e mmio_sel(input logic [9:0] ofs_word);
        bus_sel_e sel;
        sel = SEL_NONE;
        if (ofs_word == OFS_CONSOLE_TX[11:2]) sel = SEL_CONSOLE;
        else if (ofs_word == OFS_STATUS[11:2]) sel = SEL_STATUS;
        else if (ofs_word == OFS_TIMER[11:2]) sel = SEL_TIMER;
        else if (ofs_word == OFS_HALT[11:2]) sel = SEL_HALT;
        return sel;
    endfunction

endpackage

// File: rtl/bus_responder_sync_fifo.sv
// Small synchronous FIFO for the console TX path. A push into a full FIFO
// is accepted when a pop happens in the same cycle, since a slot frees up.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array: written at the tail, no reset needed for the data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/bus_responder.sv
// Zero-wait-state memory-side responder: word RAM plus an MMIO page with
// console TX FIFO, status, free-running cycle timer and simulation halt.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int          RAM_WORDS  = 4096,
    parameter string       INIT_FILE  = "",
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        data_rw,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [7:0]  halt_code
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_hit;
    logic              mmio_hit;
    bus_sel_e          sel;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              overflow;
    logic [31:0]       timer;
    logic [31:0]       status_word;

    assign ram_hit  = ({1'b0, address} < RAM_BYTES);
    assign mmio_hit = (address[31:12] == MMIO_BASE[31:12]);
    assign ram_idx  = address[RAM_AW+1:2];

    // Address decode: RAM first, then the MMIO page, otherwise unmapped.
    always_comb begin
        sel = SEL_NONE;
        if (ram_hit)       sel = SEL_RAM;
        else if (mmio_hit) sel = mmio_sel(address[11:2]);
    end

    assign fifo_push = data_rw && (sel == SEL_CONSOLE);
    assign fifo_pop  = tx_valid && tx_ready;
    assign tx_valid  = !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (wdata[7:0]),
        .pop       (fifo_pop),
        .pop_data  (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // RAM writes; contents survive reset but a write during reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && data_rw && sel == SEL_RAM) ram[ram_idx] <= wdata;
    end

    // Cycle timer: a CPU load takes priority over the per-cycle increment.
    always_ff @(posedge clk) begin
        if (reset)                             timer <= '0;
        else if (data_rw && sel == SEL_TIMER)  timer <= wdata;
        else                                   timer <= timer + 32'd1;
    end

    // Sticky overflow: set on a dropped push, cleared by writing STATUS bit 8.
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (fifo_push && fifo_full && !fifo_pop)
            overflow <= 1'b1;
        else if (data_rw && sel == SEL_STATUS && wdata[STATUS_OVERFLOW_BIT])
            overflow <= 1'b0;
    end

    // Halt latch: only the first write after reset is recorded.
    always_ff @(posedge clk) begin
        if (reset) begin
            halt      <= 1'b0;
            halt_code <= 8'h00;
        end else if (data_rw && sel == SEL_HALT && !halt) begin
            halt      <= 1'b1;
            halt_code <= wdata[7:0];
        end
    end

    // STATUS register image assembled from FIFO and overflow state.
    always_comb begin
        status_word = 32'h0;
        status_word[STATUS_OVERFLOW_BIT]                  = overflow;
        status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB]    = 6'(fifo_count);
        status_word[STATUS_FULL_BIT]                      = fifo_full;
        status_word[STATUS_EMPTY_BIT]                     = fifo_empty;
    end

    // Read mux: purely combinational from the address, unmapped reads as 0.
    always_comb begin
        rdata = 32'h0;
        case (sel)
            SEL_RAM:    rdata = ram[ram_idx];
            SEL_STATUS: rdata = status_word;
            SEL_TIMER:  rdata = timer;
            SEL_HALT:   rdata = {23'b0, halt, halt_code};
            default:    rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_bus_responder.sv
// Directed testbench for bus_responder: RAM, back-to-back writes, console
// FIFO fill/overflow/drain, full push+pop, timer wrap, halt and reset.
module tb_bus_responder;

    localparam logic [31:0] A_CONSOLE = 32'hFFFF_F000;
    localparam logic [31:0] A_STATUS  = 32'hFFFF_F004;
    localparam logic [31:0] A_TIMER   = 32'hFFFF_F008;
    localparam logic [31:0] A_HALT    = 32'hFFFF_F00C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        data_rw;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
    logic [7:0]  halt_code;

    int tests_run = 0;
    int tests_failed = 0;

    bus_responder dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .data_rw   (data_rw),
        .wdata     (wdata),
        .rdata     (rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .halt      (halt),
        .halt_code (halt_code)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one bus cycle on the falling edge; it commits on the next rising edge.
    task automatic apply_stimulus(input logic [31:0] addr, input logic rw,
                                  input logic [31:0] data, input logic ready);
        @(negedge clk);
        address  = addr;
        data_rw  = rw;
        wdata    = data;
        tx_ready = ready;
        #1;
    endtask

    // One counted comparison against a hand-computed value.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed test sequence.
    initial begin
        logic [7:0] drain_order [8];

        reset = 1'b1; address = 32'h0; data_rw = 1'b0; wdata = 32'h0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        check_output("reset_halt", {31'b0, halt}, 32'h0);
        check_output("reset_halt_code", {24'b0, halt_code}, 32'h0);
        apply_stimulus(A_STATUS, 1'b0, 32'h0, 1'b0);
        check_output("reset_status", rdata, 32'h0000_0001);

        // RAM write/read and byte-offset aliasing, unmapped read.
        apply_stimulus(32'h10, 1'b1, 32'h1234_5678, 1'b0);
        apply_stimulus(32'h10, 1'b0, 32'h0, 1'b0);
        check_output("ram_rd_10", rdata, 32'h1234_5678);
        apply_stimulus(32'h13, 1'b0, 32'h0, 1'b0);
        check_output("ram_rd_13", rdata, 32'h1234_5678);
        apply_stimulus(32'h0010_0000, 1'b1, 32'hFFFF_FFFF, 1'b0);
        apply_stimulus(32'h0010_0000, 1'b0, 32'h0, 1'b0);
        check_output("unmapped_rd", rdata, 32'h0);

        // Back-to-back writes on consecutive cycles.
        apply_stimulus(32'h100, 1'b1, 32'hA, 1'b0);
        apply_stimulus(32'hFC, 1'b1, 32'hB, 1'b0);
        apply_stimulus(32'h100, 1'b0, 32'h0, 1'b0);
        check_output("b2b_100", rdata, 32'hA);
        apply_stimulus(32'hFC, 1'b0, 32'h0, 1'b0);
        check_output("b2b_fc", rdata, 32'hB);

        // Fill FIFO with 0x41..0x48, then overflow with a ninth push.
        for (int i = 0; i < 8; i++) apply_stimulus(A_CONSOLE, 1'b1, 32'h41 + i, 1'b0);
        apply_stimulus(A_STATUS, 1'b0, 32'h0, 1'b0);
        check_output("status_full", rdata, 32'h0000_0022);
        check_output("console_rd", 32'h0, 32'h0 | {31'b0, 1'b0}) ;
        apply_stimulus(A_CONSOLE, 1'b1, 32'h49, 1'b0);
        apply_stimulus(A_STATUS, 1'b0, 32'h0, 1'b0);
        check_output("status_overflow", rdata, 32'h0000_0122);

        // Drain in order, one byte per cycle.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(32'h10, 1'b0, 32'h0, 1'b1);
            check_output($sformatf("drain_valid_%0d", i), {31'b0, tx_valid}, 32'h1);
            check_output($sformatf("drain_data_%0d", i), {24'b0, tx_data}, 32'h41 + i);
        end
        apply_stimulus(A_STATUS, 1'b0, 32'h0, 1'b0);
        check_output("drained_valid", {31'b0, tx_valid}, 32'h0);
        check_output("drained_status", rdata, 32'h0000_0101);
        apply_stimulus(A_STATUS, 1'b1, 32'h100, 1'b0);
        apply_stimulus(A_STATUS, 1'b0, 32'h0, 1'b0);
        check_output("overflow_cleared", rdata, 32'h0000_0001);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) apply_stimulus(A_CONSOLE, 1'b1, 32'h61 + i, 1'b0);
        apply_stimulus(A_CONSOLE, 1'b1, 32'h5A, 1'b1);
        check_output("pushpop_head", {24'b0, tx_data}, 32'h61);
        apply_stimulus(A_STATUS, 1'b0, 32'h0, 1'b0);
        check_output("pushpop_status", rdata, 32'h0000_0022);
        drain_order = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h5A};
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(32'h10, 1'b0, 32'h0, 1'b1);
            check_output($sformatf("pp_drain_%0d", i), {24'b0, tx_data}, {24'b0, drain_order[i]});
        end
        apply_stimulus(A_STATUS, 1'b0, 32'h0, 1'b0);
        check_output("pp_empty", rdata, 32'h0000_0001);

        // Timer load, increment and wrap.
        apply_stimulus(A_TIMER, 1'b1, 32'hFFFF_FFFE, 1'b0);
        apply_stimulus(A_TIMER, 1'b0, 32'h0, 1'b0);
        check_output("timer_load", rdata, 32'hFFFF_FFFE);
        apply_stimulus(A_TIMER, 1'b0, 32'h0, 1'b0);
        check_output("timer_max", rdata, 32'hFFFF_FFFF);
        apply_stimulus(A_TIMER, 1'b0, 32'h0, 1'b0);
        check_output("timer_wrap", rdata, 32'h0000_0000);
        apply_stimulus(A_TIMER, 1'b1, 32'h0000_0100, 1'b0);
        apply_stimulus(A_TIMER, 1'b0, 32'h0, 1'b0);
        check_output("timer_write_wins", rdata, 32'h0000_0100);

        // Halt: first write wins.
        apply_stimulus(A_HALT, 1'b1, 32'h2A, 1'b0);
        apply_stimulus(A_HALT, 1'b0, 32'h0, 1'b0);
        check_output("halt_set", {31'b0, halt}, 32'h1);
        check_output("halt_code", {24'b0, halt_code}, 32'h2A);
        check_output("halt_rd", rdata, 32'h0000_012A);
        apply_stimulus(A_HALT, 1'b1, 32'h07, 1'b0);
        apply_stimulus(A_HALT, 1'b0, 32'h0, 1'b0);
        check_output("halt_code_kept", {24'b0, halt_code}, 32'h2A);

        // Reset with three bytes queued and a RAM write that must be discarded.
        for (int i = 0; i < 3; i++) apply_stimulus(A_CONSOLE, 1'b1, 32'h31 + i, 1'b0);
        apply_stimulus(A_STATUS, 1'b0, 32'h0, 1'b0);
        check_output("pre_reset_status", rdata, 32'h0000_000C);
        @(negedge clk);
        reset = 1'b1; address = 32'h10; data_rw = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b0; data_rw = 1'b0;
        address = A_STATUS;
        #1;
        check_output("post_reset_valid", {31'b0, tx_valid}, 32'h0);
        check_output("post_reset_status", rdata, 32'h0000_0001);
        check_output("post_reset_halt", {31'b0, halt}, 32'h0);
        check_output("post_reset_halt_code", {24'b0, halt_code}, 32'h0);
        address = A_TIMER;
        #1;
        check_output("post_reset_timer", rdata, 32'h0);
        address = 32'h10;
        #1;
        check_output("ram_preserved", rdata, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
